sha256_ctrl: RTL and testbench
==============================

SHA256_CTRL -- requirements
Module: sha256_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: compression rounds per 512-bit block.
REQ-002 SHALL have parameter NBW, default 8: width of the block-count fields.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  synchronous, active-high; returns the block to IDLE.
REQ-006 SHALL have port start  input  1  one-cycle request to hash a message.
REQ-007 SHALL have port num_blocks  input  NBW  number of padded 512-bit blocks in the message; sampled with start.
REQ-008 SHALL have port blk_valid  input  1  upstream has a padded block on the datapath input.
REQ-009 SHALL have port blk_ready  output  1  controller accepts a block this cycle.
REQ-010 SHALL have port init_h  output  1  datapath loads the SHA-256 IV into H0..H7.
REQ-011 SHALL have port load_w  output  1  datapath loads the block into W and copies H into a..h.
REQ-012 SHALL have port round_en  output  1  datapath executes one round.
REQ-013 SHALL have port round_idx  output  6  round number t, used to select K[t] and W[t].
REQ-014 SHALL have port update_h  output  1  datapath adds a..h into H0..H7.
REQ-015 SHALL have port blk_count  output  NBW  number of blocks completed in the current message.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port hash_valid  output  1  the digest on the datapath output is final.
REQ-018 SHALL have port hash_ready  input  1  consumer takes the digest.

Function
REQ-019 SHALL implement the FSM states IDLE, INIT, WAIT_BLK, ROUND, UPDATE and DONE.
REQ-020 In IDLE, start=1 with num_blocks!=0 SHALL latch num_blocks, clear blk_count and go to INIT.
REQ-021 In IDLE, start=1 with num_blocks==0 SHALL be ignored.
REQ-022 start SHALL be ignored in every state other than IDLE, and the latched num_blocks SHALL stay unchanged.
REQ-023 INIT SHALL last exactly one cycle, with init_h=1, then go to WAIT_BLK.
REQ-024 WAIT_BLK SHALL drive blk_ready=1.
REQ-025 In WAIT_BLK, a cycle with blk_valid=1 SHALL be a handshake: load_w=1 combinationally in that cycle, round_idx cleared to 0, next state ROUND.
REQ-026 Without blk_valid, WAIT_BLK SHALL wait indefinitely.
REQ-027 blk_ready SHALL be 0 in all states except WAIT_BLK.
REQ-028 ROUND SHALL drive round_en=1 for exactly ROUNDS consecutive cycles, with round_idx=0,1,...,ROUNDS-1.
REQ-029 round_en SHALL NOT stall.
REQ-030 When round_idx==ROUNDS-1, the next state SHALL be UPDATE.
REQ-031 round_idx SHALL hold 0 outside ROUND.
REQ-032 UPDATE SHALL last exactly one cycle, with update_h=1.
REQ-033 UPDATE SHALL increment blk_count.
REQ-034 From UPDATE, the next state SHALL be DONE if blk_count+1 == latched num_blocks, else WAIT_BLK.
REQ-035 DONE SHALL hold hash_valid=1 until hash_ready=1.
REQ-036 A DONE cycle with hash_ready=1 SHALL return to IDLE; hash_valid SHALL be 0 on the next cycle.
REQ-037 blk_count SHALL hold its value in DONE and IDLE until the next accepted start.
REQ-038 Single-block latency SHALL be fixed: handshake at cycle N, round_en in cycles N+1..N+ROUNDS, update_h at N+ROUNDS+1, hash_valid from N+ROUNDS+2.
REQ-039 init_h, load_w, round_en and update_h SHALL be mutually exclusive in every cycle.
REQ-040 blk_count arithmetic SHALL be unsigned NBW-bit; num_blocks=2^NBW-1 SHALL complete without wrap.
REQ-041 All outputs SHALL be glitch-free functions of state plus blk_valid only; there SHALL be no path from hash_ready to other outputs.

Reset
REQ-042 While reset=1, the FSM SHALL go to IDLE, round_idx=0, blk_count=0 and the latched num_blocks=0.
REQ-043 While reset=1, all outputs SHALL be 0.
REQ-044 Reset SHALL take priority over start, blk_valid and hash_ready in the same cycle.
REQ-045 Reset asserted mid-ROUND or mid-DONE SHALL abort the message; no update_h or hash_valid SHALL follow.

Verification
REQ-046 Single block: start with num_blocks=1, blk_valid held high -> init_h 1 cycle, load_w 1 cycle, round_en 64 cycles with round_idx 0..63, update_h 1 cycle, hash_valid; the tb_sha256 "abc" vector digest ba7816bf...f20015ad matches.
REQ-047 Three blocks, blk_valid delayed 5 cycles before each block -> exactly 3 load_w pulses, 3 update_h pulses and 192 round_en cycles; blk_count=3 at hash_valid.
REQ-048 hash_ready held low for 10 cycles -> hash_valid stays high for 10 cycles; start pulses during this time are ignored; return to IDLE one cycle after hash_ready=1.
REQ-049 start with num_blocks=0 -> busy stays 0 and there are no strobes; start issued at round_idx=20 -> no effect on the sequence.
REQ-050 reset asserted at round_idx=30 -> next cycle all outputs are 0 and the state is IDLE; a subsequent start with num_blocks=1 hashes correctly.
REQ-051 Assertions throughout: the strobes in REQ-039 are one-hot-or-zero; blk_ready implies the WAIT_BLK state.

Source files
------------

// File: rtl/sha256_ctrl.sv
// SHA-256 block sequencer: steps the datapath through IV load, per-block W load,
// ROUNDS compression rounds and the H update, then presents the digest until taken.
module sha256_ctrl #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned NBW    = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [NBW-1:0] num_blocks,
  input  logic           blk_valid,
  output logic           blk_ready,
  output logic           init_h,
  output logic           load_w,
  output logic           round_en,
  output logic [5:0]     round_idx,
  output logic           update_h,
  output logic [NBW-1:0] blk_count,
  output logic           busy,
  output logic           hash_valid,
  input  logic           hash_ready
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StInit    = 3'd1;
  localparam logic [2:0] StWaitBlk = 3'd2;
  localparam logic [2:0] StRound   = 3'd3;
  localparam logic [2:0] StUpdate  = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  logic [2:0]     r_state;
  logic [NBW-1:0] r_num_blocks;
  logic [NBW-1:0] r_blk_count;
  logic [5:0]     r_round_idx;

  logic [2:0]     w_state_d;
  logic [NBW-1:0] w_num_blocks_d;
  logic [NBW-1:0] w_blk_count_d;
  logic [5:0]     w_round_idx_d;
  logic [NBW:0]   w_blk_count_inc;
  logic           w_run;

  // One extra bit so num_blocks = 2^NBW-1 compares without wrapping.
  assign w_blk_count_inc = {1'b0, r_blk_count} + (NBW + 1)'(1);

  always_comb begin
    w_state_d      = r_state;
    w_num_blocks_d = r_num_blocks;
    w_blk_count_d  = r_blk_count;
    w_round_idx_d  = r_round_idx;
    case (r_state)
      StIdle: begin
        if (start && (num_blocks != '0)) begin
          w_num_blocks_d = num_blocks;
          w_blk_count_d  = '0;
          w_state_d      = StInit;
        end
      end
      StInit: w_state_d = StWaitBlk;
      StWaitBlk: begin
        if (blk_valid) begin
          w_round_idx_d = '0;
          w_state_d     = StRound;
        end
      end
      StRound: begin
        if (r_round_idx == LastRound) begin
          w_round_idx_d = '0;
          w_state_d     = StUpdate;
        end else begin
          w_round_idx_d = r_round_idx + 6'd1;
        end
      end
      StUpdate: begin
        w_blk_count_d = w_blk_count_inc[NBW-1:0];
        w_state_d     = (w_blk_count_inc == {1'b0, r_num_blocks}) ? StDone : StWaitBlk;
      end
      StDone: begin
        if (hash_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_num_blocks <= '0;
      r_blk_count  <= '0;
      r_round_idx  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_num_blocks <= w_num_blocks_d;
      r_blk_count  <= w_blk_count_d;
      r_round_idx  <= w_round_idx_d;
    end
  end

  // Outputs are forced low during the reset cycle itself, before the state register clears.
  assign w_run      = ~reset;
  assign blk_ready  = w_run && (r_state == StWaitBlk);
  assign init_h     = w_run && (r_state == StInit);
  assign load_w     = w_run && (r_state == StWaitBlk) && blk_valid;
  assign round_en   = w_run && (r_state == StRound);
  assign round_idx  = w_run ? r_round_idx : 6'd0;
  assign update_h   = w_run && (r_state == StUpdate);
  assign blk_count  = w_run ? r_blk_count : '0;
  assign busy       = w_run && (r_state != StIdle);
  assign hash_valid = w_run && (r_state == StDone);

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed bench for sha256_ctrl: a behavioural SHA-256 datapath follows the strobes,
// and a scoreboard of per-message expectations is checked when hash_valid rises.
module tb_sha256_ctrl;
  localparam int ROUNDS = 64;
  localparam int NBW    = 8;
  localparam logic [255:0] AbcDigest =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [NBW-1:0] num_blocks = '0;
  logic           blk_valid = 1'b0;
  logic           hash_ready = 1'b0;
  logic           blk_ready, init_h, load_w, round_en, update_h, busy, hash_valid;
  logic [5:0]     round_idx;
  logic [NBW-1:0] blk_count;

  sha256_ctrl #(.ROUNDS(ROUNDS), .NBW(NBW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .init_h(init_h), .load_w(load_w),
    .round_en(round_en), .round_idx(round_idx), .update_h(update_h),
    .blk_count(blk_count), .busy(busy), .hash_valid(hash_valid), .hash_ready(hash_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] digest;
    logic         chk_digest;
    int           cnt;
    int           n_load;
    int           n_upd;
    int           n_rnd;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] hreg [8];
  logic [31:0] st [8];
  logic [31:0] wsch [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Datapath acts at negedge, where the strobes are stable for the whole cycle.
  always @(negedge clk) begin : dp
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    if (!reset) begin
      if (init_h) for (int i = 0; i < 8; i++) hreg[i] <= iv[i];
      if (load_w) begin
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        w[0]  = 32'h61626380;
        w[15] = 32'h00000018;
        for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
        wsch <= w;
        st   <= hreg;
      end
      if (round_en) begin
        s  = st;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
           + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k_tab[round_idx] + wsch[round_idx];
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        st <= '{t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
      end
      if (update_h) for (int i = 0; i < 8; i++) hreg[i] <= hreg[i] + st[i];
    end
  end

  // ---------------- protocol monitor + scoreboard ----------------
  int   n_load = 0, n_upd = 0, n_rnd = 0, exp_idx = 0, last_load = 0, last_upd = 0;
  logic prev_hv = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      check("reset_outputs_zero", 256'({blk_ready, init_h, load_w, round_en, round_idx,
            update_h, blk_count, busy, hash_valid}), 256'(0));
      prev_hv <= 1'b0;
      exp_idx <= 0;
    end else begin
      check("strobes_onehot0", 256'($onehot0({init_h, load_w, round_en, update_h})), 256'(1));
      if (blk_ready)
        check("ready_implies_wait", 256'({busy, init_h, round_en, update_h, hash_valid}),
              256'(5'b10000));
      if (init_h) begin
        n_load <= 0; n_upd <= 0; n_rnd <= 0;
      end
      if (load_w) begin
        n_load <= n_load + 1; exp_idx <= 0; last_load <= cyc;
      end
      if (round_en) begin
        check("round_idx_seq", 256'(round_idx), 256'(exp_idx));
        exp_idx <= exp_idx + 1;
        n_rnd   <= n_rnd + 1;
      end else begin
        check("round_idx_idle", 256'(round_idx), 256'(0));
      end
      if (update_h) begin
        check("update_latency", 256'(cyc - last_load), 256'(ROUNDS + 1));
        n_upd    <= n_upd + 1;
        last_upd <= cyc;
      end
      if (hash_valid && !prev_hv) begin
        check("hv_latency", 256'(cyc - last_upd), 256'(1));
        if (sb.size() == 0) begin
          check("unexpected_hash_valid", 256'(hash_valid), 256'(0));
        end else begin
          e = sb.pop_front();
          check("blk_count_at_hv", 256'(blk_count), 256'(e.cnt));
          check("load_w_pulses", 256'(n_load), 256'(e.n_load));
          check("update_h_pulses", 256'(n_upd), 256'(e.n_upd));
          check("round_en_cycles", 256'(n_rnd), 256'(e.n_rnd));
          if (e.chk_digest)
            check("digest", {hreg[0], hreg[1], hreg[2], hreg[3], hreg[4], hreg[5], hreg[6],
                  hreg[7]}, e.digest);
        end
      end
      prev_hv <= hash_valid;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start(input logic [NBW-1:0] n);
    start = 1'b1; num_blocks = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_hv(input int budget);
    int i = 0;
    while (!hash_valid && i < budget) begin @(negedge clk); i++; end
    check("hv_timeout", 256'(hash_valid), 256'(1));
  endtask

  task automatic ack_hv();
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    check("hv_drop_after_ack", 256'({hash_valid, busy}), 256'(0));
  endtask

  task automatic wait_round(input int idx);
    int i = 0;
    while (!(round_en && round_idx == 6'(idx)) && i < 200) begin @(negedge clk); i++; end
    check("round_reach", 256'(round_idx), 256'(idx));
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 256'({busy, blk_count}), 256'(0));

    // Single "abc" block with blk_valid held high.
    e = '{AbcDigest, 1'b1, 1, 1, 1, ROUNDS}; sb.push_back(e);
    blk_valid = 1'b1;
    pulse_start(1);
    check("init_pulse", 256'({init_h, busy, blk_ready}), 256'(3'b110));
    @(negedge clk);
    check("handshake", 256'({load_w, blk_ready}), 256'(2'b11));
    wait_hv(200);
    ack_hv();
    blk_valid = 1'b0;

    // Three blocks, each offered 5 cycles after blk_ready rises.
    e = '{256'(0), 1'b0, 3, 3, 3, 3 * ROUNDS}; sb.push_back(e);
    pulse_start(3);
    for (int b = 0; b < 3; b++) begin
      int i = 0;
      while (!blk_ready && i < 200) begin @(negedge clk); i++; end
      repeat (5) @(negedge clk);
      check("wait_holds", 256'({blk_ready, load_w}), 256'(2'b10));
      blk_valid = 1'b1;
      #1 check("load_w_comb", 256'(load_w), 256'(1));
      @(negedge clk);
      blk_valid = 1'b0;
    end
    wait_hv(400);

    // Consumer stalls 10 cycles; start inside DONE must be ignored.
    for (int i = 0; i < 10; i++) begin
      check("hv_hold", 256'(hash_valid), 256'(1));
      start = (i == 3); num_blocks = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    ack_hv();
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", 256'(busy), 256'(0));
    check("cnt_hold_idle", 256'(blk_count), 256'(3));

    // num_blocks == 0 is not a request.
    pulse_start(0);
    repeat (5) begin
      check("zero_blocks_ignored", 256'({busy, init_h, load_w, round_en, update_h}), 256'(0));
      @(negedge clk);
    end

    // start during ROUND must not change the latched block count.
    e = '{AbcDigest, 1'b1, 1, 1, 1, ROUNDS}; sb.push_back(e);
    blk_valid = 1'b1;
    pulse_start(1);
    wait_round(20);
    pulse_start(3);
    wait_hv(200);
    ack_hv();

    // Reset mid-ROUND aborts the message.
    pulse_start(1);
    wait_round(30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_abort_idle", 256'({blk_ready, init_h, load_w, round_en, round_idx, update_h,
          blk_count, busy, hash_valid}), 256'(0));
    repeat (3) @(negedge clk);
    check("no_update_after_abort", 256'({n_upd, busy}), 256'(0));
    e = '{AbcDigest, 1'b1, 1, 1, 1, ROUNDS}; sb.push_back(e);
    pulse_start(1);
    wait_hv(200);
    ack_hv();

    // Largest block count completes without wrapping.
    e = '{256'(0), 1'b0, 255, 255, 255, 255 * ROUNDS}; sb.push_back(e);
    pulse_start(8'd255);
    wait_hv(20000);
    ack_hv();
    blk_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
